imem_fetch_sequencer: RTL and testbench
=======================================

# imem_fetch_sequencer

Fetch controller for the single-cycle LEGv8 core. Owns the program counter, drives the address of the read-only instruction memory, and waits a programmable number of wait states for read data to settle. It then presents each fetched word to the decoder through a valid/ready handshake. Branch and CBZ redirects from execute, plus a halt request, are sequenced here so the memory is never sampled mid-read.

## Interface
- WAIT_CYCLES, default 1: extra cycles the address is held before data is sampled; legal range 0..15.
- CLK  in  1  rising-edge clock.
- resetl  in  1  asynchronous, active-low reset.
- startpc  in  64  PC loaded during reset; must be stable while resetl=0.
- imem_addr  out  64  address to instruction memory; always equals the internal PC register.
- imem_data  in  32  instruction word from memory.
- instr  out  32  captured instruction.
- instr_pc  out  64  address `instr` was fetched from.
- instr_valid  out  1  `instr` and `instr_pc` are valid.
- instr_ready  in  1  decoder accepts `instr` this cycle.
- redirect  in  1  taken branch or CBZ; load `redirect_target`.
- redirect_target  in  64  new PC; must be word-aligned.
- halt  in  1  stop fetching.
- halted  out  1  sequencer is in HALTED.
- misalign  out  1  sticky flag; set by an unaligned redirect.
- fetch_count  out  32  count of completed handshakes; wraps at 2^32.

## Operation
- States: FETCH, HOLD, HALTED. Internal registers: `pc`, `wait_cnt` (4 bits).
- Reset values:
  - state = FETCH, pc = startpc, wait_cnt = WAIT_CYCLES.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - halted = 0, misalign = 0, fetch_count = 0.
- FETCH:
  - If wait_cnt ≠ 0, decrement it.
  - If wait_cnt = 0: instr ← imem_data, instr_pc ← pc, pc ← pc+4 (modulo 2^64, wraps to 0), instr_valid ← 1, go to HOLD.
- HOLD:
  - `instr`, `instr_pc` and `instr_valid` are held stable.
  - On instr_valid & instr_ready: fetch_count increments, instr_valid ← 0, wait_cnt ← WAIT_CYCLES, go to FETCH.
- HALTED:
  - instr_valid = 0, halted = 1, pc frozen.
  - Only reset exits this state; redirect and instr_ready are ignored.
- Event priority at each edge, outside HALTED (highest first):
  1. halt: go to HALTED. A pending HOLD handshake still completes this edge if instr_ready=1, and fetch_count counts it. Otherwise the held instruction is dropped.
  2. redirect:
     - If redirect_target[1:0] ≠ 0: misalign ← 1, go to HALTED.
     - Else: pc ← redirect_target, instr_valid ← 0, wait_cnt ← WAIT_CYCLES, go to FETCH.
     - Any in-flight fetch is aborted. A HOLD word with instr_ready=1 on the same edge is counted as delivered.
  3. Normal state behaviour.
- Reset asserted mid-fetch or mid-hold asynchronously restores all reset values. No partial state survives.

## Timing
- `imem_addr` is the registered PC; it changes only on a clock edge or on reset.
- Fetch latency, from entering FETCH to instr_valid=1, is WAIT_CYCLES+1 edges.
- Minimum issue interval with instr_ready held at 1 is WAIT_CYCLES+2 cycles per instruction.
- instr_valid never deasserts in HOLD without a handshake, halt, redirect, or reset.
- A redirect takes effect at the edge where it is sampled. The first word from the target is valid WAIT_CYCLES+1 edges later.
- halt and redirect are sampled only at edges; glitches between edges are ignored.

## Test plan
1. Reset sequence, WAIT_CYCLES=1:
   - Stimulus: startpc=0, memory holds F84003E9@0 and F84083EA@4, instr_ready=1.
   - Required: first instr=F84003E9 with instr_pc=0, valid on the 2nd edge after resetl rises.
   - Required: second instr=F84083EA with instr_pc=4, valid 3 cycles later. fetch_count=2 after the second handshake.
2. Backpressure:
   - Stimulus: hold instr_ready=0 for 5 cycles in HOLD.
   - Required: instr, instr_pc and instr_valid stay stable, imem_addr stays at instr_pc+4, fetch_count unchanged.
   - Then assert instr_ready=1 for one cycle: exactly one increment of fetch_count.
3. Redirect:
   - Stimulus: redirect=1, redirect_target=0x1C, asserted during a FETCH wait state.
   - Required: the old fetch is discarded, imem_addr=0x1C on the next edge, the next instr_pc=0x1C.
   - Repeat with redirect and instr_ready=1 on the same HOLD edge: fetch_count increments, next instr_pc=0x1C.
4. Misaligned redirect:
   - Stimulus: redirect_target=0x22.
   - Required: misalign=1 and halted=1 on the next edge, instr_valid=0.
   - Further redirects are ignored. Only reset clears misalign.
5. Halt priority:
   - Stimulus: halt=1 and redirect=1 (target 0x40) on the same edge.
   - Required: HALTED, pc unchanged (not 0x40), halted=1.
6. Wrap and zero wait:
   - Stimulus: WAIT_CYCLES=0, startpc=0xFFFFFFFFFFFFFFFC.
   - Required: instr_pc=0xFFFF…FFFC, then imem_addr=0, the next instr_pc=0, issue interval 2 cycles.
   - Required: resetl pulsed low mid-HOLD immediately clears instr_valid and reloads startpc.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, waits WAIT_CYCLES for imem data,
// then offers each word to decode over valid/ready. Halt and redirect preempt fetch.
module imem_fetch_sequencer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  input  logic        halt,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [63:0] pc;
  logic [3:0]  wait_cnt;
  logic        handshake;

  assign handshake = (state == HOLD) && instr_valid && instr_ready;
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= FETCH;
      pc          <= startpc;
      wait_cnt    <= WAIT_INIT;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else if (state != HALTED) begin
      // A word already on offer is delivered even if halt/redirect wins this edge.
      if (handshake) fetch_count <= fetch_count + 32'd1;
      if (halt) begin
        state       <= HALTED;
        instr_valid <= 1'b0;
      end else if (redirect) begin
        instr_valid <= 1'b0;
        if (|redirect_target[1:0]) begin
          misalign <= 1'b1;
          state    <= HALTED;
        end else begin
          pc       <= redirect_target;
          wait_cnt <= WAIT_INIT;
          state    <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            if (wait_cnt != 4'd0) begin
              wait_cnt <= wait_cnt - 4'd1;
            end else begin
              instr       <= imem_data;
              instr_pc    <= pc;
              pc          <= pc + 64'd4;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              wait_cnt    <= WAIT_INIT;
              state       <= FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: two instances (WAIT 1 and 0) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_imem_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc0, startpc1;
  logic        instr_ready, redirect, halt;
  logic [63:0] redirect_target;

  logic [63:0] addr0, addr1, ipc0, ipc1;
  logic [31:0] data0, data1, instr0, instr1, cnt0, cnt1;
  logic        vld0, vld1, hlt0, hlt1, mis0, mis1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h4:   return 32'hF84083EA;
      default: return a[31:0] ^ 32'h8B1F03E0;
    endcase
  endfunction

  assign data0 = memf(addr0);
  assign data1 = memf(addr1);

  imem_fetch_sequencer #(.WAIT_CYCLES(1)) u0 (
    .CLK(CLK), .resetl(resetl), .startpc(startpc0), .imem_addr(addr0), .imem_data(data0),
    .instr(instr0), .instr_pc(ipc0), .instr_valid(vld0), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target), .halt(halt),
    .halted(hlt0), .misalign(mis0), .fetch_count(cnt0));

  imem_fetch_sequencer #(.WAIT_CYCLES(0)) u1 (
    .CLK(CLK), .resetl(resetl), .startpc(startpc1), .imem_addr(addr1), .imem_data(data1),
    .instr(instr1), .instr_pc(ipc1), .instr_valid(vld1), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target), .halt(halt),
    .halted(hlt1), .misalign(mis1), .fetch_count(cnt1));

  // Model: a word is either on offer (valid) or "left" edges away from capture.
  typedef struct {
    logic [63:0] pc;
    int          left;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t mreset(input logic [63:0] spc, input int w);
    mstate_t n;
    n.pc = spc; n.left = w; n.valid = 1'b0; n.instr = '0; n.ipc = '0;
    n.halted = 1'b0; n.mis = 1'b0; n.cnt = '0;
    return n;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int w, input logic h,
                                    input logic r, input logic [63:0] tgt, input logic rdy);
    mstate_t n = s;
    if (s.halted) return n;
    if (h || r) begin
      if (s.valid && rdy) n.cnt = s.cnt + 1;
      n.valid = 1'b0;
      if (h || tgt[1:0] != 2'b00) begin
        n.halted = 1'b1;
        if (!h) n.mis = 1'b1;
      end else begin
        n.pc = tgt;
        n.left = w;
      end
    end else if (s.valid) begin
      if (rdy) begin
        n.cnt = s.cnt + 1;
        n.valid = 1'b0;
        n.left = w;
      end
    end else if (s.left > 0) begin
      n.left = s.left - 1;
    end else begin
      n.instr = memf(s.pc);
      n.ipc = s.pc;
      n.pc = s.pc + 64'd4;
      n.valid = 1'b1;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      m0 <= mreset(startpc0, 1);
      m1 <= mreset(startpc1, 0);
    end else begin
      m0 <= mstep(m0, 1, halt, redirect, redirect_target, instr_ready);
      m1 <= mstep(m1, 0, halt, redirect, redirect_target, instr_ready);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    chk("u0.addr", addr0, m0.pc);      chk("u1.addr", addr1, m1.pc);
    chk("u0.valid", vld0, m0.valid);   chk("u1.valid", vld1, m1.valid);
    chk("u0.instr", instr0, m0.instr); chk("u1.instr", instr1, m1.instr);
    chk("u0.ipc", ipc0, m0.ipc);       chk("u1.ipc", ipc1, m1.ipc);
    chk("u0.halted", hlt0, m0.halted); chk("u1.halted", hlt1, m1.halted);
    chk("u0.mis", mis0, m0.mis);       chk("u1.mis", mis1, m1.mis);
    chk("u0.cnt", cnt0, m0.cnt);       chk("u1.cnt", cnt1, m1.cnt);
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    resetl = 1'b0;
    startpc0 = 64'h0;
    startpc1 = 64'hFFFF_FFFF_FFFF_FFFC;
    instr_ready = 1'b1;
    redirect = 1'b0;
    halt = 1'b0;
    redirect_target = '0;
    tick(); tick();
    chk("rst.valid", vld0, 1'b0);
    chk("rst.cnt", cnt0, 32'd0);
    chk("rst.addr0", addr0, 64'h0);
    chk("rst.addr1", addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    resetl = 1'b1;

    // first fetch: valid on the 2nd edge after reset release
    tick(); chk("t1.notyet", vld0, 1'b0);
    tick(); chk("t1.v", vld0, 1'b1); chk("t1.instr", instr0, 32'hF84003E9); chk("t1.ipc", ipc0, 64'h0);
    tick(); chk("t1.cnt", cnt0, 32'd1); chk("t1.drop", vld0, 1'b0);
    tick(); tick();
    chk("t1.v2", vld0, 1'b1); chk("t1.instr2", instr0, 32'hF84083EA); chk("t1.ipc2", ipc0, 64'h4);

    // backpressure
    instr_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t2.v", vld0, 1'b1); chk("t2.ipc", ipc0, 64'h4);
      chk("t2.addr", addr0, 64'h8); chk("t2.cnt", cnt0, 32'd1);
    end
    instr_ready = 1'b1;
    tick(); chk("t2.cnt2", cnt0, 32'd2); chk("t2.v0", vld0, 1'b0);
    instr_ready = 1'b0;

    // redirect during a FETCH wait state
    redirect = 1'b1; redirect_target = 64'h1C;
    tick(); chk("t3.addr", addr0, 64'h1C); chk("t3.v", vld0, 1'b0);
    redirect = 1'b0;
    tick(); chk("t3.wait", vld0, 1'b0);
    tick(); chk("t3.v1", vld0, 1'b1); chk("t3.ipc", ipc0, 64'h1C);

    // redirect coinciding with a handshake in HOLD
    instr_ready = 1'b1; redirect = 1'b1;
    tick(); chk("t3b.cnt", cnt0, 32'd3); chk("t3b.v", vld0, 1'b0); chk("t3b.addr", addr0, 64'h1C);
    instr_ready = 1'b0; redirect = 1'b0;
    tick(); tick(); chk("t3b.v1", vld0, 1'b1); chk("t3b.ipc", ipc0, 64'h1C);

    // misaligned redirect
    redirect = 1'b1; redirect_target = 64'h22;
    tick(); chk("t4.mis", mis0, 1'b1); chk("t4.hlt", hlt0, 1'b1); chk("t4.v", vld0, 1'b0);
    chk("t4.addr", addr0, 64'h20);
    redirect_target = 64'h40; instr_ready = 1'b1;
    tick(); tick(); chk("t4.frozen", addr0, 64'h20); chk("t4.cnt", cnt0, 32'd3); chk("t4.mis2", mis0, 1'b1);
    redirect = 1'b0; instr_ready = 1'b0;
    resetl = 1'b0;
    tick(); chk("t4.rst.mis", mis0, 1'b0); chk("t4.rst.hlt", hlt0, 1'b0); chk("t4.rst.addr", addr0, 64'h0);
    resetl = 1'b1;

    // halt beats redirect on the same edge
    tick(); tick(); chk("t5.v", vld0, 1'b1);
    halt = 1'b1; redirect = 1'b1; redirect_target = 64'h40;
    tick(); chk("t5.hlt", hlt0, 1'b1); chk("t5.addr", addr0, 64'h4); chk("t5.v0", vld0, 1'b0);
    chk("t5.mis", mis0, 1'b0);
    halt = 1'b0; redirect = 1'b0;
    tick(); chk("t5.frozen", addr0, 64'h4);

    // zero wait states and PC wrap
    resetl = 1'b0; instr_ready = 1'b1;
    tick(); resetl = 1'b1;
    tick(); chk("t6.v", vld1, 1'b1); chk("t6.ipc", ipc1, 64'hFFFF_FFFF_FFFF_FFFC); chk("t6.addr", addr1, 64'h0);
    tick(); chk("t6.v0", vld1, 1'b0); chk("t6.cnt", cnt1, 32'd1);
    tick(); chk("t6.v1", vld1, 1'b1); chk("t6.ipc2", ipc1, 64'h0); chk("t6.addr2", addr1, 64'h4);
    instr_ready = 1'b0;
    tick(); chk("t6.hold", vld1, 1'b1);
    #2 resetl = 1'b0;
    #1 chk("t6.async.v", vld1, 1'b0); chk("t6.async.addr", addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6.async.cnt", cnt1, 32'd0);
    tick(); resetl = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
